// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg : shared encodings for the timer_counter block.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  localparam logic [1:0] c_OFF_CTRL   = 2'd0;
  localparam logic [1:0] c_OFF_PRESET = 2'd1;
  localparam logic [1:0] c_OFF_COUNT  = 2'd2;

  localparam int c_CTRL_EN      = 0;
  localparam int c_CTRL_MODE_LO = 1;
  localparam int c_CTRL_MODE_HI = 2;
  localparam int c_CTRL_IM      = 3;
  localparam int c_CTRL_W       = 4;

  localparam logic [1:0] c_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] c_MODE_RELOAD  = 2'b01;

endpackage

`default_nettype wire

// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter : memory-mapped down-counter timer (one-shot / auto-reload).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module timer_counter
  import timer_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter logic [27:0] BASE_HI = 28'h0000_7F0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  logic [c_CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0]   preset_q;
  logic [DATA_W-1:0]   count_q;
  state_e              state_q;
  logic                irq_flag_q;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_en;
  logic w_reload;
  logic w_unused_base;

  // Address match against BASE_HI is done by the bridge.
  assign w_unused_base = ^BASE_HI;

  assign w_wr_ctrl   = we && (addr == c_OFF_CTRL);
  assign w_wr_preset = we && (addr == c_OFF_PRESET);
  assign w_en        = ctrl_q[c_CTRL_EN];
  assign w_reload    = (ctrl_q[c_CTRL_MODE_HI:c_CTRL_MODE_LO] == c_MODE_RELOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      irq_flag_q <= 1'b0;
    end else begin
      // Bus clear first so a same-edge set from the FSM takes priority.
      if (w_wr_ctrl || w_wr_preset) irq_flag_q <= 1'b0;
      if (w_wr_preset)              preset_q   <= wdata;

      case (state_q)
        S_IDLE: if (w_en) state_q <= S_LOAD;
        S_LOAD: begin
          count_q <= preset_q;
          state_q <= S_CNT;
        end
        S_CNT: begin
          if (!w_en) begin
            state_q <= S_IDLE;
          end else if (count_q == '0) begin
            state_q    <= S_INT;
            irq_flag_q <= 1'b1;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        S_INT: begin
          if (w_reload) begin
            irq_flag_q <= 1'b0;
            state_q    <= S_LOAD;
          end else begin
            ctrl_q[c_CTRL_EN] <= 1'b0;
            state_q           <= S_IDLE;
          end
        end
      endcase

      // Placed after the FSM so a CPU write overrides the one-shot En clear.
      if (w_wr_ctrl) ctrl_q <= wdata[c_CTRL_W-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      c_OFF_CTRL:   rdata = {{(DATA_W-c_CTRL_W){1'b0}}, ctrl_q};
      c_OFF_PRESET: rdata = preset_q;
      c_OFF_COUNT:  rdata = count_q;
      default:      rdata = '0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[c_CTRL_IM];

endmodule

`default_nettype wire

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_counter : directed self-checking bench for timer_counter.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  timer_counter #(.DATA_W(32), .BASE_HI(28'h0000_7F0)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      checks++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h want 0", a, v);
      end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    wr(2'd2, 32'd5);
    rd(2'd2, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL count_ro: got %h want 0", v); end
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reserved_rd: got %h want 0", v); end
    rd(2'd0, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reserved_wr_ctrl: got %h want 0", v); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hFFFF_FFF9);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      rd(2'd2, v);
      checks++;
      if (v !== 32'(3 - k)) begin
        errors++;
        $display("FAIL oneshot_count[%0d]: got %0d want %0d", k, v, 3 - k);
      end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_early_irq[%0d]: got %b want 0", k, irq); end
      tick();
    end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_rise: got %b want 1", irq); end
    tick();
    rd(2'd0, v);
    checks++;
    if (v !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl_after: got %h want 8", v); end
    repeat (3) tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_hold: got %b want 1", irq); end
    wr(2'd1, 32'd7);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear: got %b want 0", irq); end
    rd(2'd1, v);
    checks++;
    if (v !== 32'd7) begin errors++; $display("FAIL preset_rd: got %0d want 7", v); end
  endtask

  task automatic test_periodic();
    logic [31:0] v;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (irq !== ((k % 5) == 0)) begin
        errors++;
        $display("FAIL periodic_irq[%0d]: got %b want %b", k, irq, ((k % 5) == 0));
      end
    end
    rd(2'd0, v);
    checks++;
    if (v !== 32'hB) begin errors++; $display("FAIL periodic_ctrl: got %h want b", v); end
    wr(2'd0, 32'h0);
    repeat (3) tick();
  endtask

  task automatic test_mask();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h3);
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq[%0d]: got %b want 0", k, irq); end
    end
    // Enabling IM on the edge that sets the flag exposes that pulse.
    wr(2'd0, 32'hB);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL unmask_coincide: got %b want 1", irq); end
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL unmask_pulse_end: got %b want 0", irq); end
    wr(2'd0, 32'h0);
    repeat (2) tick();
  endtask

  task automatic test_freeze();
    logic [31:0] v;
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h1);
    repeat (6) tick();
    rd(2'd2, v);
    checks++;
    if (v !== 32'd5) begin errors++; $display("FAIL freeze_pre: got %0d want 5", v); end
    wr(2'd0, 32'h0);
    for (int k = 0; k < 11; k++) begin
      rd(2'd2, v);
      checks++;
      if (v !== 32'd4) begin errors++; $display("FAIL freeze_hold[%0d]: got %0d want 4", k, v); end
      tick();
    end
    wr(2'd0, 32'h9);
    tick();
    rd(2'd2, v);
    checks++;
    if (v !== 32'd4) begin errors++; $display("FAIL restart_load: got %0d want 4", v); end
    tick();
    rd(2'd2, v);
    checks++;
    if (v !== 32'd9) begin errors++; $display("FAIL restart_reload: got %0d want 9", v); end
    wr(2'd0, 32'h0);
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    repeat (5) tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL areset_pre_irq: got %b want 1", irq); end
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL areset_irq: got %b want 0", irq); end
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL areset_regs[%0d]: got %h want 0", a, v); end
    end
    reset = 1'b0;
    tick();
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h1);
    repeat (4) tick();
    rd(2'd2, v);
    checks++;
    if (v !== 32'd7) begin errors++; $display("FAIL areset_mid_pre: got %0d want 7", v); end
    #1 reset = 1'b1;
    #1;
    for (int a = 0; a < 3; a++) begin
      rd(a[1:0], v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL areset_mid[%0d]: got %h want 0", a, v); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL areset_mid_irq: got %b want 0", irq); end
    reset = 1'b0;
    repeat (3) tick();
    rd(2'd2, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL areset_idle_count: got %0d want 0", v); end
  endtask

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_mask();
    test_freeze();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
